// File: rtl/issue_pkg.sv
// issue_pkg: opcodes, ALU select codes, FSM states and operand forming shared by the issue block and ALU bench
package issue_pkg;
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;

   typedef enum logic [2:0] {
      SEL_PASS = 3'b000,
      SEL_ADD  = 3'b001,
      SEL_AND  = 3'b010,
      SEL_OR   = 3'b011
   } alu_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_e;

   // Only the fields the datapath consumes; RS is imm[2:0].
   typedef struct packed {
      logic [7:0] op;
      logic [2:0] rd;
      logic [2:0] rt;
      logic [7:0] imm;
   } instr_t;

   typedef struct packed {
      logic [7:0] data1;
      logic [7:0] data2;
      alu_sel_e   sel;
   } operands_t;

   function automatic logic is_legal(input logic [7:0] op);
      return op <= OP_OR;
   endfunction

   // Sub reuses the adder by negating the RS operand (mod 256).
   function automatic operands_t form_operands(input logic [7:0] op, input logic [7:0] rt_val,
                                               input logic [7:0] rs_val, input logic [7:0] imm);
      operands_t o;
      o.data1 = (op >= OP_ADD && op <= OP_OR) ? rt_val : 8'h00;
      o.data2 = (op == OP_LOADI) ? imm : (op == OP_SUB) ? 8'h00 - rs_val : rs_val;
      o.sel   = (op == OP_ADD || op == OP_SUB) ? SEL_ADD :
                (op == OP_AND) ? SEL_AND :
                (op == OP_OR)  ? SEL_OR  : SEL_PASS;
      return o;
   endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 8x8 register file, two combinational read ports, one write port
//   clk, rst            : clock, synchronous active-high reset clearing all registers
//   rd_addr1/rd_data1   : read port 1
//   rd_addr2/rd_data2   : read port 2
//   we, wr_addr, wr_data: write port, written on the rising edge
module reg_file (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] rd_addr1,
   output logic [7:0] rd_data1,
   input  logic [2:0] rd_addr2,
   output logic [7:0] rd_data2,
   input  logic       we,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data
);
   logic [7:0] regs_q [8];
   logic [7:0] regs_d [8];

   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[wr_addr] = wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) regs_q <= '{default: 8'h00};
      else     regs_q <= regs_d;
   end

   assign rd_data1 = regs_q[rd_addr1];
   assign rd_data2 = regs_q[rd_addr2];
endmodule

// File: rtl/operand_issue.sv
// operand_issue: decodes one instruction, reads operands, drives an external ALU and writes back
//   CLK, RESET                   : clock, synchronous active-high reset
//   INSTR, INSTR_VALID/READY     : instruction handshake (READY only in IDLE)
//   ALU_DATA1/2, ALU_SELECT      : ALU operands and op, nonzero only in EXEC
//   ALU_RESULT                   : combinational ALU result
//   DONE, ERR, WB_ADDR, WB_DATA  : completion info, nonzero only in WB
module operand_issue
   import issue_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTR,
   input  logic        INSTR_VALID,
   output logic        INSTR_READY,
   output logic [7:0]  ALU_DATA1,
   output logic [7:0]  ALU_DATA2,
   output logic [2:0]  ALU_SELECT,
   input  logic [7:0]  ALU_RESULT,
   output logic        DONE,
   output logic        ERR,
   output logic [2:0]  WB_ADDR,
   output logic [7:0]  WB_DATA
);
   state_e    state_q, state_d;
   instr_t    instr_q, instr_d;
   operands_t ops_q, ops_d;
   logic      done_q, done_d;
   logic      err_q, err_d;
   logic [2:0] wb_addr_q, wb_addr_d;
   logic [7:0] wb_data_q, wb_data_d;
   logic [7:0] rt_val, rs_val;
   logic       unused_instr_bits;

   // Upper bits of the register fields carry no meaning.
   assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};

   reg_file u_reg_file (
      .clk      (CLK),
      .rst      (RESET),
      .rd_addr1 (instr_q.rt),
      .rd_data1 (rt_val),
      .rd_addr2 (instr_q.imm[2:0]),
      .rd_data2 (rs_val),
      .we       (state_q == ST_WB && !err_q),
      .wr_addr  (wb_addr_q),
      .wr_data  (wb_data_q)
   );

   // Operand and completion registers are loaded only on the edge entering
   // EXEC / WB and cleared otherwise, so outputs are zero outside those states.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      ops_d     = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      wb_addr_d = 3'd0;
      wb_data_d = 8'h00;
      case (state_q)
         ST_IDLE: if (INSTR_VALID) begin
            instr_d = '{op: INSTR[31:24], rd: INSTR[18:16], rt: INSTR[10:8], imm: INSTR[7:0]};
            state_d = ST_READ;
         end
         ST_READ: if (is_legal(instr_q.op)) begin
            ops_d   = form_operands(instr_q.op, rt_val, rs_val, instr_q.imm);
            state_d = ST_EXEC;
         end else begin
            done_d    = 1'b1;
            err_d     = 1'b1;
            wb_addr_d = instr_q.rd;
            state_d   = ST_WB;
         end
         ST_EXEC: begin
            done_d    = 1'b1;
            wb_addr_d = instr_q.rd;
            wb_data_d = ALU_RESULT;
            state_d   = ST_WB;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         ops_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         wb_addr_q <= 3'd0;
         wb_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         ops_q     <= ops_d;
         done_q    <= done_d;
         err_q     <= err_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign INSTR_READY = state_q == ST_IDLE;
   assign ALU_DATA1   = ops_q.data1;
   assign ALU_DATA2   = ops_q.data2;
   assign ALU_SELECT  = ops_q.sel;
   assign DONE        = done_q;
   assign ERR         = err_q;
   assign WB_ADDR     = wb_addr_q;
   assign WB_DATA     = wb_data_q;
endmodule

// File: tb/tb_operand_issue.sv
// tb_operand_issue: directed and random instructions checked against a behavioural register model
module tb_operand_issue;
   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] INSTR = 32'h0;
   logic        INSTR_VALID = 1'b0;
   logic        INSTR_READY;
   logic [7:0]  ALU_DATA1, ALU_DATA2, ALU_RESULT, WB_DATA;
   logic [2:0]  ALU_SELECT, WB_ADDR;
   logic        DONE, ERR;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  mregs [8];

   always #5 CLK = ~CLK;

   // Stand-in for the external ALU.
   assign ALU_RESULT = (ALU_SELECT == 3'b001) ? ALU_DATA1 + ALU_DATA2 :
                       (ALU_SELECT == 3'b010) ? ALU_DATA1 & ALU_DATA2 :
                       (ALU_SELECT == 3'b011) ? ALU_DATA1 | ALU_DATA2 : ALU_DATA2;

   operand_issue dut (
      .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
      .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT), .ALU_RESULT(ALU_RESULT),
      .DONE(DONE), .ERR(ERR), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] rd, input logic [7:0] rt,
                                      input logic [7:0] rs);
      return {op, rd, rt, rs};
   endfunction

   // Called at a negedge while idle; returns at the negedge of the cycle after WB.
   task automatic issue(input logic [31:0] ins);
      logic [7:0] op, imm, a, b, res, d1, d2;
      logic [2:0] rd, sel;
      logic       legal;
      op    = ins[31:24];
      rd    = ins[18:16];
      imm   = ins[7:0];
      a     = mregs[ins[10:8]];
      b     = mregs[ins[2:0]];
      legal = op <= 8'h05;
      case (op)
         8'h00:   res = imm;
         8'h01:   res = b;
         8'h02:   res = a + b;
         8'h03:   res = a - b;
         8'h04:   res = a & b;
         8'h05:   res = a | b;
         default: res = 8'h00;
      endcase
      d1  = (op >= 8'h02 && op <= 8'h05) ? a : 8'h00;
      d2  = (op == 8'h00) ? imm : (op == 8'h03) ? 8'h00 - b : b;
      sel = (op == 8'h02 || op == 8'h03) ? 3'd1 : (op == 8'h04) ? 3'd2 : (op == 8'h05) ? 3'd3 : 3'd0;
      check("idle_ready", {31'd0, INSTR_READY}, 1);
      INSTR = ins;
      INSTR_VALID = 1'b1;
      @(negedge CLK);
      INSTR_VALID = $urandom_range(0, 1);
      INSTR = $urandom;
      check("read_ready", {31'd0, INSTR_READY}, 0);
      check("read_done", {31'd0, DONE}, 0);
      check("read_alu", {13'd0, ALU_DATA1, ALU_DATA2, ALU_SELECT}, 0);
      @(negedge CLK);
      if (legal) begin
         check("exec_data1", {24'd0, ALU_DATA1}, {24'd0, d1});
         check("exec_data2", {24'd0, ALU_DATA2}, {24'd0, d2});
         check("exec_select", {29'd0, ALU_SELECT}, {29'd0, sel});
         check("exec_done", {31'd0, DONE}, 0);
         @(negedge CLK);
      end
      check("wb_done", {31'd0, DONE}, 1);
      check("wb_err", {31'd0, ERR}, {31'd0, !legal});
      check("wb_data", {24'd0, WB_DATA}, legal ? {24'd0, res} : 0);
      if (legal) check("wb_addr", {29'd0, WB_ADDR}, {29'd0, rd});
      check("wb_alu", {13'd0, ALU_DATA1, ALU_DATA2, ALU_SELECT}, 0);
      if (legal) mregs[rd] = res;
      INSTR_VALID = 1'b0;
      @(negedge CLK);
      check("post_ready", {31'd0, INSTR_READY}, 1);
      check("post_wb", {19'd0, DONE, ERR, WB_ADDR, WB_DATA}, 0);
   endtask

   // mov Rk,Rk exposes Rk on WB_DATA without changing it.
   task automatic check_regs();
      for (int k = 0; k < 8; k++) issue(mk(8'h01, 8'(k), 8'h00, 8'(k)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 8; k++) mregs[k] = 8'h00;
      repeat (2) @(negedge CLK);
      check("rst_ready", {31'd0, INSTR_READY}, 1);
      check("rst_outs", {13'd0, DONE, ERR, WB_ADDR, WB_DATA, ALU_DATA1, ALU_DATA2, ALU_SELECT} & 32'h7ffff, 0);
      check("rst_outs2", {31'd0, ALU_DATA1 != 0 || ALU_DATA2 != 0 || ALU_SELECT != 0}, 0);
      RESET = 1'b0;
      check_regs();
      issue(mk(8'h00, 8'd1, 8'd0, 8'h05));
      issue(mk(8'h00, 8'd2, 8'd0, 8'h03));
      issue(mk(8'h02, 8'd3, 8'd1, 8'd2));
      issue(mk(8'h03, 8'd4, 8'd1, 8'd2));
      issue(mk(8'h04, 8'd5, 8'd1, 8'd2));
      issue(mk(8'h05, 8'd6, 8'd1, 8'd2));
      issue(mk(8'h01, 8'd7, 8'd0, 8'd6));
      check("r7_model", {24'd0, mregs[7]}, 32'h07);
      issue(mk(8'h03, 8'd0, 8'd0, 8'd0));
      issue(mk(8'hFF, 8'd3, 8'd1, 8'd2));
      check_regs();
      issue(mk(8'h02, 8'hF9, 8'hFA, 8'hFB));
      // Reset during EXEC of loadi R1,0xAA abandons it.
      INSTR = mk(8'h00, 8'd1, 8'd0, 8'hAA);
      INSTR_VALID = 1'b1;
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      @(negedge CLK);
      check("abort_exec_data2", {24'd0, ALU_DATA2}, 32'hAA);
      RESET = 1'b1;
      @(negedge CLK);
      check("abort_done", {31'd0, DONE}, 0);
      check("abort_ready", {31'd0, INSTR_READY}, 1);
      RESET = 1'b0;
      for (int k = 0; k < 8; k++) mregs[k] = 8'h00;
      @(negedge CLK);
      check("abort_done2", {31'd0, DONE}, 0);
      check("abort_ready2", {31'd0, INSTR_READY}, 1);
      check_regs();
      // Continuous VALID: one accept every 4 cycles.
      begin
         int n_acc, n_done;
         n_acc = 0;
         n_done = 0;
         INSTR = mk(8'h00, 8'd3, 8'd0, 8'h11);
         INSTR_VALID = 1'b1;
         for (int c = 0; c < 16; c++) begin
            if (INSTR_READY) n_acc++;
            if (DONE) n_done++;
            @(negedge CLK);
         end
         INSTR_VALID = 1'b0;
         mregs[3] = 8'h11;
         check("stream_accepts", n_acc, 4);
         check("stream_dones", n_done, 4);
         check("stream_ready", {31'd0, INSTR_READY}, 1);
      end
      // Reset together with VALID: no accept.
      INSTR = mk(8'h00, 8'd5, 8'd0, 8'h66);
      INSTR_VALID = 1'b1;
      RESET = 1'b1;
      @(negedge CLK);
      check("rstvalid_ready", {31'd0, INSTR_READY}, 1);
      RESET = 1'b0;
      INSTR_VALID = 1'b0;
      for (int k = 0; k < 8; k++) mregs[k] = 8'h00;
      @(negedge CLK);
      check("rstvalid_ready2", {31'd0, INSTR_READY}, 1);
      check("rstvalid_done", {31'd0, DONE}, 0);
      check_regs();
      // Random instructions with random idle gaps.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] w;
         int r;
         r = $urandom_range(0, 11);
         w = $urandom;
         w[31:24] = (r <= 7) ? 8'(r % 6) : (r <= 10) ? 8'($urandom_range(6, 255)) : 8'hFF;
         repeat ($urandom_range(0, 2)) begin
            INSTR = $urandom;
            check("gap_ready", {31'd0, INSTR_READY}, 1);
            @(negedge CLK);
         end
         issue(w);
      end
      check_regs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
